// File: rtl/channel_selector.sv
// Active-channel register for the VGA source mux: bus select/query with a registered ack,
// next/prev buttons that skip disabled channels, button lock, and a change pulse.
module channel_selector #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [CH_W-1:0]   channel,
  output logic              chg
);

  logic              lock;
  logic              busy;
  logic              btn_next_q;
  logic              btn_prev_q;
  logic [CH_W-1:0]   channel_q;
  logic [NUM_CH-1:0] en_eff;

  logic              accept;
  logic              is_query;
  logic              sel_ok;
  logic [CH_W-1:0]   sel_ch;
  logic              lock_d;
  logic [DATA_W-1:0] data_out_d;
  logic              data_out_valid_d;

  logic              next_edge;
  logic              prev_edge;
  logic              fallback;
  logic              step;
  logic              up_found;
  logic              down_found;
  logic [CH_W-1:0]   up_ch;
  logic [CH_W-1:0]   down_ch;
  logic [CH_W-1:0]   idx_up;
  logic [CH_W-1:0]   idx_down;
  logic [CH_W-1:0]   channel_d;

  // Channel 0 is always eligible, which also guarantees every button search terminates.
  assign en_eff = en | {{(NUM_CH-1){1'b0}}, 1'b1};

  // Request handshake: a request is taken when valid is high and the block is not busy;
  // ack follows one cycle later and the block stays busy for that ack cycle.
  always_comb begin
    accept           = valid && !busy;
    is_query         = (data == '1);
    sel_ok           = 1'b0;
    sel_ch           = '0;
    lock_d           = lock;
    data_out_d       = '0;
    data_out_valid_d = 1'b0;
    if (accept) begin
      case (address)
        ADDR_W'(0): sel_ok = 1'b1;
        ADDR_W'(2): begin
          if (is_query) begin
            data_out_valid_d = 1'b1;
            data_out_d       = DATA_W'(channel);
          end else if (int'(data) < NUM_CH && en_eff[data[CH_W-1:0]]) begin
            sel_ok = 1'b1;
            sel_ch = data[CH_W-1:0];
          end
        end
        ADDR_W'(4): begin
          if (is_query) begin
            data_out_valid_d = 1'b1;
            data_out_d       = DATA_W'(lock);
          end else begin
            lock_d = data[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Wrap-around search for the nearest enabled channel in each direction.
  always_comb begin
    up_ch      = '0;
    down_ch    = '0;
    up_found   = 1'b0;
    down_found = 1'b0;
    idx_up     = '0;
    idx_down   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_up   = CH_W'((int'(channel) + i) % NUM_CH);
      idx_down = CH_W'((int'(channel) + NUM_CH - i) % NUM_CH);
      if (!up_found && en_eff[idx_up]) begin
        up_found = 1'b1;
        up_ch    = idx_up;
      end
      if (!down_found && en_eff[idx_down]) begin
        down_found = 1'b1;
        down_ch    = idx_down;
      end
    end
  end

  always_comb begin
    next_edge = btn_next && !btn_next_q;
    prev_edge = btn_prev && !btn_prev_q;
    fallback  = !en_eff[channel];
    step      = !lock && (next_edge != prev_edge);
    if (fallback) begin
      channel_d = '0;
    end else if (sel_ok) begin
      channel_d = sel_ch;
    end else if (step) begin
      channel_d = next_edge ? up_ch : down_ch;
    end else begin
      channel_d = channel;
    end
  end

  // Button history resets to 1 so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      channel        <= '0;
      channel_q      <= '0;
      chg            <= 1'b0;
      lock           <= 1'b0;
      busy           <= 1'b0;
      ack            <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      btn_next_q     <= 1'b1;
      btn_prev_q     <= 1'b1;
    end else begin
      channel        <= channel_d;
      channel_q      <= channel;
      chg            <= (channel != channel_q);
      lock           <= lock_d;
      busy           <= accept;
      ack            <= accept;
      data_out       <= data_out_d;
      data_out_valid <= data_out_valid_d;
      btn_next_q     <= btn_next;
      btn_prev_q     <= btn_prev;
    end
  end

endmodule

// File: tb/tb_channel_selector.sv
// Bench for channel_selector: directed scenarios plus random traffic, scored against
// a behavioural model; a negedge monitor pops per-cycle and per-ack expectations.
module tb_channel_selector;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              btn_next;
  logic              btn_prev;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ack;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic [CH_W-1:0]   channel;
  logic              chg;

  channel_selector #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en), .btn_next(btn_next), .btn_prev(btn_prev),
    .address(address), .data(data), .valid(valid), .ack(ack), .data_out(data_out),
    .data_out_valid(data_out_valid), .channel(channel), .chg(chg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {ack, data_out_valid, data_out, channel, chg} expected after each edge
  logic [8:0] exp_q[$];
  // {data_out_valid, data_out} expected on each ack
  logic [4:0] resp_q[$];

  int   m_ch;
  logic m_lock, m_busy, m_bn_q, m_bp_q, m_pending;

  function automatic logic ch_enabled(int c);
    return (c == 0) || en[c];
  endfunction

  function automatic int search_up(int c);
    int n = c;
    do n = (n == NUM_CH - 1) ? 0 : n + 1; while (!ch_enabled(n));
    return n;
  endfunction

  function automatic int search_down(int c);
    int n = c;
    do n = (n == 0) ? NUM_CH - 1 : n - 1; while (!ch_enabled(n));
    return n;
  endfunction

  task automatic model_step();
    logic       acc, dov, sel_ok, ne, pe, chg_e, new_lock;
    logic [3:0] dout;
    int         old_ch, new_ch, tgt;
    if (rst) begin
      m_ch = 0; m_lock = 0; m_busy = 0; m_bn_q = 1; m_bp_q = 1; m_pending = 0;
      exp_q.push_back(9'd0);
      return;
    end
    old_ch   = m_ch;
    acc      = valid && !m_busy;
    ne       = btn_next && !m_bn_q;
    pe       = btn_prev && !m_bp_q;
    dov      = 0;
    dout     = 0;
    sel_ok   = 0;
    tgt      = 0;
    new_lock = m_lock;
    if (acc) begin
      if (address == 4'h0) begin
        sel_ok = 1;
      end else if (address == 4'h2) begin
        if (data == 4'hF) begin
          dov = 1; dout = 4'(m_ch);
        end else if (int'(data) < NUM_CH && ch_enabled(int'(data))) begin
          sel_ok = 1; tgt = int'(data);
        end
      end else if (address == 4'h4) begin
        if (data == 4'hF) begin
          dov = 1; dout = {3'b000, m_lock};
        end else begin
          new_lock = data[0];
        end
      end
    end
    if (!ch_enabled(m_ch))             new_ch = 0;
    else if (sel_ok)                   new_ch = tgt;
    else if (!m_lock && ne && !pe)     new_ch = search_up(m_ch);
    else if (!m_lock && pe && !ne)     new_ch = search_down(m_ch);
    else                               new_ch = m_ch;
    chg_e     = m_pending;
    m_pending = (new_ch != old_ch);
    exp_q.push_back({acc, dov, dout, 2'(new_ch), chg_e});
    if (acc) resp_q.push_back({dov, dout});
    m_ch = new_ch; m_lock = new_lock; m_busy = acc; m_bn_q = btn_next; m_bp_q = btn_prev;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic req(logic [3:0] a, logic [3:0] d);
    valid = 1; address = a; data = d;
    tick();
    valid = 0;
    tick();
  endtask

  task automatic press(logic n, logic p, string name, int want);
    btn_next = n; btn_prev = p;
    tick();
    chk(name, channel, want);
    btn_next = 0; btn_prev = 0;
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] e;
    logic [4:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e != {ack, data_out_valid, data_out, channel, chg}) begin
        failures++;
        $display("FAIL cycle_state {ack,dov,dout,ch,chg} got=%b_%b_%h_%0d_%b expected=%b_%b_%h_%0d_%b at %0t",
                 ack, data_out_valid, data_out, channel, chg, e[8], e[7], e[6:3], e[2:1], e[0], $time);
      end
    end
    if (ack) begin
      checks++;
      if (resp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack got=1 expected=0 at %0t", $time);
      end else begin
        r = resp_q.pop_front();
        if (r != {data_out_valid, data_out}) begin
          failures++;
          $display("FAIL ack_response got=%b_%h expected=%b_%h at %0t",
                   data_out_valid, data_out, r[4], r[3:0], $time);
        end
      end
    end
  end

  initial begin
    rst = 1; en = 4'hF; btn_next = 0; btn_prev = 0; address = 0; data = 0; valid = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("reset_channel", channel, 0);
    chk("reset_ack", ack, 0);

    // select 3 with valid held through the ack cycle
    valid = 1; address = 4'h2; data = 4'h3;
    tick();
    chk("sel3_channel", channel, 3);
    chk("sel3_ack", ack, 1);
    tick();
    chk("held_valid_no_ack", ack, 0);
    chk("sel3_chg", chg, 1);
    valid = 0;
    tick();

    // query current channel
    req(4'h2, 4'h2);
    valid = 1; address = 4'h2; data = 4'hF;
    tick();
    chk("query_ch_data", data_out, 2);
    chk("query_ch_dov", data_out_valid, 1);
    chk("query_ch_ack", ack, 1);
    valid = 0;
    tick();
    chk("query_after_data", data_out, 0);
    chk("query_after_dov", data_out_valid, 0);

    // button stepping with en=0101
    req(4'h0, 4'h0);
    en = 4'b0101;
    tick();
    press(1, 0, "next_0_to_2", 2);
    press(1, 0, "next_2_to_0", 0);
    press(0, 1, "prev_0_to_2", 2);
    press(1, 1, "both_no_change", 2);

    // reject disabled target, then fallback when current channel is disabled
    valid = 1; address = 4'h2; data = 4'h1;
    tick();
    chk("reject_ack", ack, 1);
    chk("reject_channel", channel, 2);
    valid = 0;
    tick();
    en = 4'b0001;
    tick();
    chk("fallback_channel", channel, 0);
    tick();
    chk("fallback_chg", chg, 1);

    // lock
    en = 4'hF;
    req(4'h4, 4'h1);
    press(1, 0, "locked_next", 0);
    valid = 1; address = 4'h4; data = 4'hF;
    tick();
    chk("lock_query", data_out, 1);
    valid = 0;
    tick();
    req(4'h4, 4'h0);
    press(1, 0, "unlocked_next", 1);

    // bus select and button in the same cycle
    req(4'h0, 4'h0);
    valid = 1; address = 4'h2; data = 4'h1; btn_next = 1;
    tick();
    chk("collision_channel", channel, 1);
    valid = 0; btn_next = 0;
    tick();

    // button held across reset
    btn_next = 1; rst = 1;
    repeat (2) tick();
    rst = 0;
    repeat (2) tick();
    chk("held_btn_reset", channel, 0);
    btn_next = 0;
    tick();

    // reset in the cycle the request is taken: no ack
    req(4'h2, 4'h2);
    valid = 1; address = 4'h2; data = 4'h3; rst = 1;
    tick();
    chk("rst_drop_ack", ack, 0);
    chk("rst_drop_channel", channel, 0);
    rst = 0; valid = 0;
    tick();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 3) == 0) btn_prev = ~btn_prev;
      valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       address = 4'h0;
        1, 3:    address = 4'h2;
        2:       address = 4'h4;
        default: address = 4'($urandom_range(0, 15));
      endcase
      data = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      tick();
    end

    rst = 0; valid = 0; btn_next = 0; btn_prev = 0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
